// File: rtl/wr_port_arbiter.sv
// wr_port_arbiter
//
// Four-requester round-robin arbiter for a small register file write port.
// A requester raises its req bit together with a 3-bit register index and a
// data word. When the arbiter is idle and enabled it selects a winner, latches
// that requester's index and data, and spends exactly one WRITE cycle driving
// the one-hot grant and the decoded write strobe. It then returns to IDLE, so a
// new write can start at most every second cycle. Register 0 is hard-wired to
// zero, so a write to index 0 is granted but produces no strobe.
//
// Ports
//   clk        : single clock, all state updates on its rising edge
//   rst_n      : asynchronous active-low reset
//   arb_en     : global enable; when low no new grant is issued
//   req        : one request bit per requester
//   req_addr   : requester i register index in bits [3i+2:3i]
//   req_data   : requester i write data in bits [DATA_W*(i+1)-1:DATA_W*i]
//   gnt        : one-hot grant, high during WRITE only
//   we_onehot  : decoded register write strobe, high during WRITE only
//   wr_addr    : latched register index of the current/last write
//   wr_data    : latched data of the current/last write
//   busy       : high while in WRITE
//
// Every output comes straight from a flop; there is no combinational path
// from any input to any output.

module wr_port_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arb_en,
  input  logic [3:0]            req,
  input  logic [11:0]           req_addr,
  input  logic [4*DATA_W-1:0]   req_data,
  output logic [3:0]            gnt,
  output logic [7:0]            we_onehot,
  output logic [2:0]            wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [1:0]          win_q, win_d;
  logic [3:0]          gnt_q, gnt_d;
  logic [7:0]          we_q, we_d;
  logic [2:0]          wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                busy_q, busy_d;

  logic                found;
  logic [1:0]          pick;
  logic [1:0]          cand;
  logic [2:0]          sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [7:0]          sel_we;

  // Round-robin search: walk upward from ptr with 2-bit wrap-around and take
  // the first requester whose bit is set.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = ptr_q;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Steer the winner's index and data onto a single bus.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) == pick) begin
        sel_addr = req_addr[3*i +: 3];
        sel_data = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  // Index 0 is the hard-wired zero register: it gets no strobe.
  always_comb begin
    sel_we = 8'b0000_0001 << sel_addr;
    if (sel_addr == 3'd0) begin
      sel_we = 8'h00;
    end
  end

  // Next-state and registered-output logic. Strobes default to zero so they
  // are only ever high for the single WRITE cycle; the latched index/data
  // default to holding their value.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    gnt_d     = 4'b0000;
    we_d      = 8'h00;
    busy_d    = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      IDLE: begin
        if (arb_en && found) begin
          state_d   = WRITE;
          win_d     = pick;
          gnt_d     = 4'b0001 << pick;
          we_d      = sel_we;
          busy_d    = 1'b1;
          wr_addr_d = sel_addr;
          wr_data_d = sel_data;
        end
      end
      WRITE: begin
        // The write always completes; arb_en and req are not looked at here,
        // and the pointer only advances once the write has actually finished.
        state_d = IDLE;
        ptr_d   = win_q + 2'd1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously so a write in flight
  // is discarded the instant reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      win_q     <= 2'd0;
      gnt_q     <= 4'b0000;
      we_q      <= 8'h00;
      busy_q    <= 1'b0;
      wr_addr_q <= 3'd0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      gnt_q     <= gnt_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign gnt       = gnt_q;
  assign we_onehot = we_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_wr_port_arbiter.sv
// tb_wr_port_arbiter
//
// Directed bench for wr_port_arbiter. A table of {arb_en, req, expected
// outputs} records is stepped one clock at a time from reset, followed by
// hand-written sequences for round-robin rotation, enable gating and reset
// during a write. Register indices and data per requester are fixed:
//   requester 0 : index 5, data A5A5A5A5
//   requester 1 : index 3, data BBBB0001
//   requester 2 : index 0, data CCCC0002
//   requester 3 : index 7, data DDDD0003

module tb_wr_port_arbiter;

  localparam int DATA_W = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 arb_en;
  logic [3:0]           req;
  logic [11:0]          req_addr;
  logic [4*DATA_W-1:0]  req_data;
  logic [3:0]           gnt;
  logic [7:0]           we_onehot;
  logic [2:0]           wr_addr;
  logic [DATA_W-1:0]    wr_data;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic [3:0]  req;
    logic [3:0]  eg;
    logic [7:0]  ewe;
    logic        ebusy;
    logic [2:0]  ewa;
    logic [31:0] ewd;
  } vec_t;

  vec_t       vecs[16];
  logic [3:0] rr_exp[10];

  wr_port_arbiter #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb_en    (arb_en),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .gnt       (gnt),
    .we_onehot (we_onehot),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic en, input logic [3:0] r,
                              input logic [3:0] eg, input logic [7:0] ewe,
                              input logic ebusy, input logic [2:0] ewa,
                              input logic [31:0] ewd);
    vec_t v;
    v.en = en; v.req = r; v.eg = eg; v.ewe = ewe;
    v.ebusy = ebusy; v.ewa = ewa; v.ewd = ewd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] eg,
                          input logic [7:0] ewe, input logic ebusy,
                          input logic [2:0] ewa, input logic [31:0] ewd);
    checkOutput({tag, ".gnt"},     32'(gnt),       32'(eg));
    checkOutput({tag, ".we"},      32'(we_onehot), 32'(ewe));
    checkOutput({tag, ".busy"},    32'(busy),      32'(ebusy));
    checkOutput({tag, ".wr_addr"}, 32'(wr_addr),   32'(ewa));
    checkOutput({tag, ".wr_data"}, wr_data,        ewd);
  endtask

  // Drive inputs, let one rising edge pass, then settle away from the edge.
  task automatic applyStimulus(input logic en, input logic [3:0] r);
    arb_en = en;
    req    = r;
    @(posedge clk);
    #1;
  endtask

  // Reset is released on a falling edge so the next rising edge is the first
  // one that sees rst_n high.
  task automatic doReset();
    rst_n  = 1'b0;
    arb_en = 1'b0;
    req    = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    req_addr = {3'd7, 3'd0, 3'd3, 3'd5};
    req_data = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hA5A5A5A5};

    //             en    req      gnt      we     busy ewa   wr_data
    vecs[0]  = mk(1'b1, 4'b0001, 4'b0001, 8'h20, 1'b1, 3'd5, 32'hA5A5A5A5);
    vecs[1]  = mk(1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0, 3'd5, 32'hA5A5A5A5);
    vecs[2]  = mk(1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0, 3'd5, 32'hA5A5A5A5);
    vecs[3]  = mk(1'b0, 4'b1111, 4'b0000, 8'h00, 1'b0, 3'd5, 32'hA5A5A5A5);
    vecs[4]  = mk(1'b0, 4'b1111, 4'b0000, 8'h00, 1'b0, 3'd5, 32'hA5A5A5A5);
    vecs[5]  = mk(1'b1, 4'b1111, 4'b0010, 8'h08, 1'b1, 3'd3, 32'hBBBB0001);
    vecs[6]  = mk(1'b1, 4'b1111, 4'b0000, 8'h00, 1'b0, 3'd3, 32'hBBBB0001);
    vecs[7]  = mk(1'b1, 4'b1111, 4'b0100, 8'h00, 1'b1, 3'd0, 32'hCCCC0002);
    vecs[8]  = mk(1'b0, 4'b1111, 4'b0000, 8'h00, 1'b0, 3'd0, 32'hCCCC0002);
    vecs[9]  = mk(1'b1, 4'b0011, 4'b0001, 8'h20, 1'b1, 3'd5, 32'hA5A5A5A5);
    vecs[10] = mk(1'b1, 4'b1000, 4'b0000, 8'h00, 1'b0, 3'd5, 32'hA5A5A5A5);
    vecs[11] = mk(1'b1, 4'b1000, 4'b1000, 8'h80, 1'b1, 3'd7, 32'hDDDD0003);
    vecs[12] = mk(1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0, 3'd7, 32'hDDDD0003);
    vecs[13] = mk(1'b1, 4'b0110, 4'b0010, 8'h08, 1'b1, 3'd3, 32'hBBBB0001);
    vecs[14] = mk(1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0, 3'd3, 32'hBBBB0001);
    vecs[15] = mk(1'b1, 4'b0110, 4'b0100, 8'h00, 1'b1, 3'd0, 32'hCCCC0002);

    rr_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
               4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};

    // Reset state.
    doReset();
    #1;
    checkAll("reset", 4'b0000, 8'h00, 1'b0, 3'd0, 32'h0);

    // Table-driven sequence from reset.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].en, vecs[i].req);
      checkAll($sformatf("vec%0d", i), vecs[i].eg, vecs[i].ewe,
               vecs[i].ebusy, vecs[i].ewa, vecs[i].ewd);
    end

    // Round robin with all four requests held.
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 4'b1111);
      checkOutput($sformatf("rr%0d.gnt", i), 32'(gnt), 32'(rr_exp[i]));
      checkOutput($sformatf("rr%0d.busy", i), 32'(busy),
                  32'(rr_exp[i] != 4'b0000));
    end

    // Enable gating.
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'b1111);
      checkOutput($sformatf("gate%0d.gnt", i), 32'(gnt), 32'h0);
      checkOutput($sformatf("gate%0d.busy", i), 32'(busy), 32'h0);
    end
    applyStimulus(1'b1, 4'b1111);
    checkAll("gate_en", 4'b0001, 8'h20, 1'b1, 3'd5, 32'hA5A5A5A5);

    // Reset in the middle of a write, with ptr moved away from 0 first.
    doReset();
    applyStimulus(1'b1, 4'b0010);
    checkOutput("mid.pre_gnt", 32'(gnt), 32'h2);
    applyStimulus(1'b1, 4'b0000);
    applyStimulus(1'b1, 4'b0100);
    checkOutput("mid.busy", 32'(busy), 32'h1);
    checkOutput("mid.gnt", 32'(gnt), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    checkAll("mid.async", 4'b0000, 8'h00, 1'b0, 3'd0, 32'h0);
    arb_en = 1'b1;
    req    = 4'b1111;
    @(negedge clk);
    checkAll("mid.held", 4'b0000, 8'h00, 1'b0, 3'd0, 32'h0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 4'b1111);
    checkAll("mid.ptr0", 4'b0001, 8'h20, 1'b1, 3'd5, 32'hA5A5A5A5);
    applyStimulus(1'b1, 4'b0000);
    applyStimulus(1'b1, 4'b0010);
    checkAll("mid.rereq", 4'b0010, 8'h08, 1'b1, 3'd3, 32'hBBBB0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
